// File: rtl/video_pkg.sv
// Shared types for the video capture path.
//   fifo_entry_t : one FIFO entry, start-of-frame flag plus a 32-bit pixel word.
//   Status word  : {level[15:0], drop_cnt[15:0]}, returned on bus reads.
package video_pkg;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int          STAT_FIELD_W  = 16;
  localparam int          STAT_LEVEL_LSB = 16;
  localparam int          STAT_DROP_LSB  = 0;
  localparam logic [3:0]  SEL_ALL        = 4'hF;
  localparam logic [15:0] DROP_CNT_MAX   = 16'hFFFF;

  function automatic logic [31:0] status_word(input logic [STAT_FIELD_W-1:0] level,
                                              input logic [STAT_FIELD_W-1:0] drop_cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_LEVEL_LSB +: STAT_FIELD_W] = level;
    w[STAT_DROP_LSB  +: STAT_FIELD_W] = drop_cnt;
    return w;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle.
//   master -> slave : cyc, stb, we, adr, dat_ms, sel, cti, bte
//   slave -> master : ack, err, rty, dat_sm
interface wshb_if #(
  parameter int DATA_BYTES = 4
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [DATA_BYTES*8-1:0] dat_ms;
  logic [DATA_BYTES*8-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output ack, err, rty, dat_sm);
  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  ack, err, rty, dat_sm);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level.
//   sys_clk/sys_rst : clock, async active-high reset (pointers and level only)
//   i_push/i_wdata  : write; ignored when full
//   i_pop           : read advance; ignored when empty
//   o_rdata         : head entry, combinational from registered state, 0 when empty
//   o_full/o_empty/o_level : registered occupancy, level in 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Gated so the head reads as zero while empty (including during reset),
  // since the storage array itself is not reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/wshb_stream_sink.sv
// Wishbone classic slave that queues written pixel words into a FIFO and
// presents them as a valid/ready stream.
//   sys_clk, sys_rst : clock, async active-high reset
//   wshb_ifs         : Wishbone slave; full-word writes push, partial writes
//                      are dropped with err, reads return {level, drop_cnt}
//   out_valid/out_ready/out_data/out_sof : stream of FIFO head entries;
//                      out_sof marks words written at byte address 0
module wshb_stream_sink
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wshb_if.slave       wshb_ifs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sof
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;
  logic [15:0] r_drop_cnt;

  logic        w_req;
  logic        w_wr_ok;
  logic        w_wr_bad;
  logic        w_rd;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_level;
  logic [15:0] w_level16;
  fifo_entry_t w_wentry;
  fifo_entry_t w_head;
  logic        w_unused;

  // A request is live until it has been terminated; err terminates a
  // cycle just like ack, so a master still holding stb in the err cycle
  // is not counted twice.
  assign w_req    = wshb_ifs.cyc & wshb_ifs.stb & ~r_ack & ~r_err;
  assign w_wr_ok  = w_req & wshb_ifs.we & (wshb_ifs.sel == SEL_ALL);
  assign w_wr_bad = w_req & wshb_ifs.we & (wshb_ifs.sel != SEL_ALL);
  assign w_rd     = w_req & ~wshb_ifs.we;
  // Fullness is the registered level: a same-cycle pop does not make room,
  // the stalled write is accepted on the cycle after.
  assign w_push   = w_wr_ok & ~w_full;
  assign w_pop    = out_valid & out_ready;

  assign w_wentry.sof  = (wshb_ifs.adr == 32'h0);
  assign w_wentry.data = wshb_ifs.dat_ms;
  assign w_level16     = 16'(w_level);

  // Classic cycles only: burst tags carry no meaning here.
  assign w_unused = ^{wshb_ifs.cti, wshb_ifs.bte};

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ack <= w_push | w_rd;
      r_err <= w_wr_bad;
      // Only loaded for reads, so dat_sm is zero in every non-read cycle.
      r_dat <= w_rd ? status_word(w_level16, r_drop_cnt) : '0;
      if (w_wr_bad && r_drop_cnt != DROP_CNT_MAX)
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign wshb_ifs.ack    = r_ack;
  assign wshb_ifs.err    = r_err;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = r_dat;

  assign out_valid = ~w_empty;
  assign out_data  = w_head.data;
  assign out_sof   = w_head.sof;

endmodule

// File: tb/tb_wshb_stream_sink.sv
module tb_wshb_stream_sink;
  import video_pkg::*;

  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sof;

  wshb_if #(.DATA_BYTES(4)) bus ();

  wshb_stream_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wshb_ifs  (bus.slave),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: queue of words the bus has had acknowledged and the
  // stream has not yet consumed; its size is the expected FIFO level.
  fifo_entry_t exp_q[$];
  logic [15:0] m_drop = '0;
  int          n_vec  = 0;
  int          n_err  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: checks stream output and idle bus outputs every cycle,
  // popping the model on every handshake.
  always @(negedge sys_clk) begin
    fifo_entry_t e;
    if (!sys_rst) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (!bus.ack) chk("dat_sm_idle", bus.dat_sm, 32'h0);
      chk("rty", 32'(bus.rty), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(out_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sof", 32'(out_sof), 32'(e.sof));
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    bus.we     = we;
    bus.adr    = adr;
    bus.dat_ms = dat;
    bus.sel    = sel;
    bus.cti    = 3'($urandom);
    bus.bte    = 2'($urandom);
  endtask

  task automatic bus_idle();
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  // One bus transaction; the expected termination cycle comes from the
  // model: 1 normally, 2 if full but the stream pops, never if full and
  // stalled (abandoned after the bound).
  task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    int          exp_n;
    int          n;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err = we && (sel != 4'hF);
    exp_dat = {16'(exp_q.size()), m_drop};
    if (!we || exp_err || exp_q.size() < DEPTH) exp_n = 1;
    else if (out_ready)                        exp_n = 2;
    else                                       exp_n = 0;
    bus_drive(we, adr, dat, sel);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.ack || bus.err) begin
        n = i;
        break;
      end
    end
    chk("term_cycle", 32'(n), 32'(exp_n));
    rdat = bus.dat_sm;
    if (n != 0) begin
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("ack", 32'(bus.ack), 32'(!exp_err));
      if (!we) chk("rd_dat", bus.dat_sm, exp_dat);
      if (bus.ack && we) exp_q.push_back('{sof: (adr == 32'h0), data: dat});
      if (bus.err && m_drop != 16'hFFFF) m_drop++;
    end
    bus_idle();
    tick();
    chk("term_pulse", 32'({bus.ack, bus.err}), 32'h0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    out_ready = 1'b0;
    chk("drain", 32'(out_valid), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    int          r;
    bus_idle();
    bus.adr = '0; bus.dat_ms = '0; bus.sel = '0; bus.cti = '0; bus.bte = '0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_dat_sm", bus.dat_sm, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sof", 32'(out_sof), 32'h0);
    sys_rst = 1'b0;
    tick();

    // Single SOF write, consumer ready
    out_ready = 1'b1;
    bus_drive(1'b1, 32'h0, 32'hAABBCCDD, 4'hF);
    tick();
    chk("sof_ack", 32'(bus.ack), 32'h1);
    chk("sof_valid", 32'(out_valid), 32'h1);
    chk("sof_data", out_data, 32'hAABBCCDD);
    chk("sof_sof", 32'(out_sof), 32'h1);
    if (bus.ack) exp_q.push_back('{sof: 1'b1, data: 32'hAABBCCDD});
    bus_idle();
    tick();
    out_ready = 1'b0;
    tick();

    // Partial-select write is dropped; status read shows it
    xact(1'b1, 32'h4, 32'h12345678, 4'h3, rd);
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("status_after_drop", rd, 32'h0000_0001);

    // Fill to depth with consumer stalled, 17th write stalls
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(4 * (i + 1)), $urandom, 4'hF, rd);
    bus_drive(1'b1, 32'h100, 32'hC0FFEE17, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ack", 32'({bus.ack, bus.err}), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_pop_cycle_ack", 32'(bus.ack), 32'h0);
    out_ready = 1'b0;
    tick();
    chk("stall_release_ack", 32'(bus.ack), 32'h1);
    if (bus.ack) exp_q.push_back('{sof: 1'b0, data: 32'hC0FFEE17});
    bus_idle();
    tick();

    // Abandoned write while full: no push, no ack
    bus_drive(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    tick();
    chk("abandon_ack0", 32'(bus.ack), 32'h0);
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abandon_ack", 32'({bus.ack, bus.err}), 32'h0);
    end
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("abandon_level", 32'(rd[31:16]), 32'(DEPTH));
    drain();

    // Level 5 with matched push/pop across pointer wrap
    for (int i = 0; i < 5; i++) xact(1'b1, 32'(8 * (i + 1)), $urandom, 4'hF, rd);
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      bus_drive(1'b1, 32'(4 * (i + 1)), d, 4'hF);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("steady_ack", 32'(bus.ack), 32'h1);
      if (bus.ack) exp_q.push_back('{sof: 1'b0, data: d});
      bus_idle();
      tick();
    end
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("steady_level", 32'(rd[31:16]), 32'd5);
    drain();

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        out_ready = 1'($urandom);
        xact(1'b1, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, $urandom, 4'hF, rd);
      end else if (r < 85) begin
        out_ready = 1'($urandom);
        xact(1'b1, $urandom, $urandom, 4'($urandom_range(0, 14)), rd);
      end else begin
        out_ready = 1'b0;
        xact(1'b0, $urandom, $urandom, 4'($urandom), rd);
      end
    end
    drain();

    // Reset with level 8 and a write in flight
    for (int i = 0; i < 8; i++) xact(1'b1, 32'(4 * (i + 1)), $urandom, 4'hF, rd);
    bus_drive(1'b1, 32'h40, 32'h55AA55AA, 4'hF);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_ack", 32'(bus.ack), 32'h0);
    chk("midrst_data", out_data, 32'h0);
    exp_q.delete();
    m_drop = '0;
    bus_idle();
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("post_rst_status", rd, 32'h0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wshb_stream_sink.md
WSHB_STREAM_SINK -- requirements
Module: wshb_stream_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, FIFO depth in 32-bit words (power of two, 4..256).
REQ-002 SHALL have port sys_clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wshb_ifs  wshb_if.slave  DATA_BYTES=4  Wishbone classic slave (cyc, stb, we, adr[31:0], dat_ms[31:0], sel[3:0], cti, bte in; ack, err, rty, dat_sm[31:0] out).
REQ-005 SHALL have port out_valid  output  1  FIFO head word available.
REQ-006 SHALL have port out_ready  input  1  consumer accepts head word.
REQ-007 SHALL have port out_data  output  32  head pixel word.
REQ-008 SHALL have port out_sof  output  1  head word was written at byte address 0 (start of frame).

Function
REQ-009 SHALL detect a request when cyc & stb & ~ack; cti and bte ignored (classic cycles only).
REQ-010 SHALL, on a write request with sel == 4'hF and FIFO not full, push {adr==0, dat_ms} and assert ack on the next cycle for exactly one cycle.
REQ-011 SHALL, on a write request with FIFO full, withhold ack (stall) until a pop frees space; the push and ack then occur together.
REQ-012 SHALL decide fullness from the registered level only; a pop in the same cycle does not admit a push when full.
REQ-013 SHALL, on a write with sel != 4'hF, drop the word, assert err (not ack) for one cycle, and increment drop_cnt (16 bits, saturating at 16'hFFFF).
REQ-014 SHALL, on a read request, ack on the next cycle with dat_sm = {level[15:0], drop_cnt[15:0]}; level is zero-extended; reads never stall.
REQ-015 SHALL hold dat_sm at 0 whenever ack is low.
REQ-016 SHALL drive rty to constant 0.
REQ-017 SHALL drive out_valid = (level != 0), with out_data/out_sof from the head entry, combinationally from registered FIFO state.
REQ-018 SHALL pop when out_valid & out_ready; pop when empty is ignored.
REQ-019 SHALL allow a simultaneous push and pop when not full and not empty; level unchanged, pointers both advance.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.
REQ-021 SHALL hold out_data/out_sof stable while out_valid & ~out_ready.
REQ-022 SHALL have a latency of 1 cycle from push edge to out_valid high (write-through not allowed).
REQ-023 SHALL drop an abandoned request (cyc falls before ack) without push or counter update.

Reset
REQ-024 SHALL, while sys_rst is high, force ack=0, err=0, dat_sm=0, out_valid=0, out_data=0, out_sof=0, level=0, pointers=0, drop_cnt=0.
REQ-025 SHALL, on reset mid-transfer, discard all FIFO contents and any pending request; the first request after deassertion is handled as new.

Structure
REQ-026 SHALL place the FIFO entry struct type (sof bit + 32-bit data) and the status word layout constants in shared package video_pkg.
REQ-027 SHALL use one sub-module, sync_fifo (parameterised width and depth, push/pop/full/empty/level), instantiated once.
REQ-028 SHALL contain no clock-domain crossing; pixel_clk logic is outside this block.

Verification
REQ-029 SHALL cover: write adr=0 dat=32'hAABBCCDD sel=4'hF, out_ready=1 -> ack one cycle later, then out_valid=1, out_data=32'hAABBCCDD, out_sof=1.
REQ-030 SHALL cover: out_ready=0, 17 writes with FIFO_DEPTH=16 -> 16 acks, 17th stalls; raise out_ready one cycle -> 17th acked the cycle after the pop.
REQ-031 SHALL cover: write sel=4'h3 -> err one cycle, no ack, FIFO level unchanged; read -> dat_sm=32'h0000_0001 with empty FIFO.
REQ-032 SHALL cover: level=5, concurrent push and pop every cycle for 20 cycles -> level stays 5, output order equals input order across pointer wrap.
REQ-033 SHALL cover: assert sys_rst with level=8 and a stalled write pending -> out_valid=0 and ack=0 immediately; after release, read returns 32'h0.
REQ-034 SHALL cover: cyc dropped one cycle after stb with FIFO full -> no push, no ack, level remains 16.
